// File: rtl/inv_s_box.sv
// Registered AES inverse S-box: one byte in, InvSubBytes of that byte out one clock later.
// The table is computed as the inverse affine map followed by a GF(2^8) inversion (y^254).
module inv_s_box (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] A,
    output logic [7:0] B,
    output logic       out_valid
);

    logic [7:0] affine;
    logic [7:0] b_d;
    logic [7:0] b_q;
    logic       valid_q;

    // Shift-and-add product in GF(2^8), reduced by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // y^254 = y^(2+4+...+128); zero maps to zero with no special casing.
    function automatic logic [7:0] gfInv(input logic [7:0] y);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = y;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gfMul(sq, sq);
            acc = gfMul(acc, sq);
        end
        return acc;
    endfunction

    always_comb begin
        affine = {A[1:0], A[7:2]} ^ {A[4:0], A[7:5]} ^ {A[6:0], A[7]} ^ 8'h05;
        b_d    = gfInv(affine);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q     <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                b_q <= b_d;
            end
        end
    end

    assign B         = b_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_inv_s_box.sv
// Scoreboard bench for inv_s_box: driver pushes expected bytes, a negedge monitor pops and compares.
module tb_inv_s_box;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] A;
    logic [7:0] B;
    logic       out_valid;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] exp;
        logic       exh;
    } expItem_t;

    expItem_t   scoreQ[$];
    int         checks;
    int         passes;
    logic [7:0] invTab [256];
    logic [7:0] obs    [256];
    logic [7:0] row0   [16];
    logic [7:0] rowF   [16];
    bit         obsSeen[256];

    inv_s_box dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int tbMul(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if ((b >> i) & 1) p = p ^ (a << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if ((p >> i) & 1) p = p ^ (32'h11B << (i - 8));
        end
        return p;
    endfunction

    // Reference: build the forward S-box from its definition, then invert the table.
    task automatic buildModel();
        for (int x = 0; x < 256; x++) begin
            int inv;
            int s;
            inv = 0;
            for (int z = 1; z < 256; z++) begin
                if (tbMul(x, z) == 1) inv = z;
            end
            s = 0;
            for (int i = 0; i < 8; i++) begin
                int bitv;
                bitv = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8)) ^
                        (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ (8'h63 >> i)) & 1;
                s = s | (bitv << i);
            end
            invTab[s] = x[7:0];
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic v, input logic [7:0] exp, input logic exh);
        expItem_t it;
        @(negedge clk);
        A        = a;
        in_valid = v;
        if (v) begin
            it.a   = a;
            it.exp = exp;
            it.exh = exh;
            scoreQ.push_back(it);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (scoreQ.size() != 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("drain_empty", 8'(scoreQ.size()), 8'h00);
        scoreQ.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (scoreQ.size() == 0) begin
                checkOutput("unexpected_out_valid", 8'h01, 8'h00);
            end else begin
                expItem_t it;
                it = scoreQ.pop_front();
                checkOutput($sformatf("B_for_A_%02h", it.a), B, it.exp);
                if (it.exh) begin
                    obs[it.a]     = B;
                    obsSeen[it.a] = 1'b1;
                end
            end
        end
    end

    initial begin
        int cnt[256];
        checks   = 0;
        passes   = 0;
        row0     = '{8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
                     8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb};
        rowF     = '{8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
                     8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d};
        buildModel();

        // Reset held with live inputs
        rst_n    = 1'b0;
        A        = 8'hFF;
        in_valid = 1'b1;
        #2;
        checkOutput("reset_B_async", B, 8'h00);
        checkOutput("reset_valid_async", {7'b0, out_valid}, 8'h00);
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_B", B, 8'h00);
            checkOutput("reset_valid", {7'b0, out_valid}, 8'h00);
        end
        rst_n = 1'b1;
        begin
            expItem_t it;
            it.a = 8'hFF; it.exp = 8'h7D; it.exh = 1'b0;
            scoreQ.push_back(it);
        end
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
        drain();

        // Row sweeps and point checks against literal values
        for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b1, row0[i], 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(8'(8'hF0 + i), 1'b1, rowF[i], 1'b0);
        applyStimulus(8'h63, 1'b1, 8'h00, 1'b0);
        applyStimulus(8'h7C, 1'b1, 8'h01, 1'b0);
        applyStimulus(8'h53, 1'b1, 8'h50, 1'b0);
        applyStimulus(8'hED, 1'b1, 8'h53, 1'b0);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
        drain();

        // Exhaustive, row by row
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                logic [7:0] a;
                a = 8'((r << 4) | c);
                applyStimulus(a, 1'b1, invTab[a], 1'b1);
            end
        end
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
        drain();
        for (int r = 0; r < 16; r++) begin
            string line;
            line = $sformatf("[TB] row %1h:", r);
            for (int c = 0; c < 16; c++) line = {line, $sformatf(" %02h", obs[r * 16 + c])};
            $display("%s", line);
        end
        for (int v = 0; v < 256; v++) cnt[v] = 0;
        for (int a = 0; a < 256; a++) if (obsSeen[a]) cnt[obs[a]]++;
        for (int v = 0; v < 256; v++) checkOutput($sformatf("bijective_count_%02h", v), 8'(cnt[v]), 8'h01);

        // Randomized traffic with gaps
        for (int n = 0; n < 300; n++) begin
            logic [7:0] a;
            logic       v;
            a = 8'($urandom_range(0, 255));
            v = ($urandom_range(0, 9) < 7);
            applyStimulus(a, v, invTab[a], 1'b0);
        end
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
        drain();

        // Hold with in_valid low, then asynchronous reset mid-hold
        applyStimulus(8'h00, 1'b1, 8'h52, 1'b0);
        applyStimulus(8'h01, 1'b0, 8'h00, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("hold_B", B, 8'h52);
            checkOutput("hold_valid", {7'b0, out_valid}, 8'h00);
        end
        checkOutput("hold_queue_empty", 8'(scoreQ.size()), 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midhold_reset_B", B, 8'h00);
        checkOutput("midhold_reset_valid", {7'b0, out_valid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
